lcd_page_writer: RTL and testbench

LCD_PAGE_WRITER -- requirements
Module: lcd_page_writer

---
 rtl/lcd_page_writer.sv | 214 +++++++++++++++++++++
 tb/tb_lcd_page_writer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_page_writer.sv
// lcd_page_writer: streams a ROWS x COLS character buffer to an HD44780 panel.
// Each bus transfer is one slot: rs/data set up, lcd_e high for T_E_HIGH
// cycles, then lcd_e low for the controller's execution time. A frame is an
// optional clear, then per row a set-address command followed by COLS chars.
module lcd_page_writer #(
   parameter int  ROWS      = 2,
   parameter int  COLS      = 16,
   parameter int  T_E_HIGH  = 25,
   parameter int  T_CHAR    = 2500,
   parameter int  T_CMD     = 80000,
   parameter int  USE_CLEAR = 1,
   localparam int AW        = $clog2(ROWS*COLS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          init_done,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_char,
   input  logic          refresh_req,
   output logic          busy,
   output logic          frame_done,
   output logic [7:0]    lcd_data,
   output logic          lcd_rs,
   output logic          lcd_rw,
   output logic          lcd_e
);

   localparam int N         = ROWS*COLS;
   localparam int T_LOW_MAX = (T_CMD > T_CHAR) ? T_CMD : T_CHAR;
   localparam int CW        = $clog2(T_E_HIGH + T_LOW_MAX + 1);

   // Last in-slot cycle index for each slot flavour, and last lcd_e-high index.
   localparam logic [CW-1:0] CLR_LAST = CW'(T_E_HIGH + T_CMD - 1);
   localparam logic [CW-1:0] CHR_LAST = CW'(T_E_HIGH + T_CHAR - 1);
   localparam logic [CW-1:0] E_LAST   = CW'(T_E_HIGH - 1);
   localparam logic [4:0]    COL_LAST = 5'(COLS - 1);
   localparam logic [1:0]    ROW_LAST = 2'(ROWS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_SETADDR,
      S_CHAR,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      row_q, row_d;
   logic [4:0]      col_q, col_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic            pend_q, pend_d;
   logic            busy_q, busy_d;
   logic            fd_q, fd_d;
   logic            lcd_e_q, e_d;
   logic            lcd_rs_q, rs_d;
   logic [7:0]      lcd_data_q, data_d;

   logic [7:0]      buf_q [N];
   logic [7:0]      buf_d [N];

   logic            slot_end;
   logic            start_frame;
   logic            wr_ok;
   logic [AW-1:0]   nxt_idx;

   // DDRAM set-address command for a display row (rows 2/3 continue lines 0/1).
   function automatic logic [7:0] row_cmd(input logic [1:0] r);
      logic [7:0] a;
      case (r)
         2'd0:    a = 8'h00;
         2'd1:    a = 8'h40;
         2'd2:    a = 8'(COLS);
         default: a = 8'h40 + 8'(COLS);
      endcase
      return 8'h80 | a;
   endfunction

   assign slot_end    = (state_q == S_CLEAR) ? (cnt_q == CLR_LAST) : (cnt_q == CHR_LAST);
   assign start_frame = init_done && (refresh_req || pend_q) &&
                        (state_q == S_IDLE || state_q == S_DONE);
   assign wr_ok       = wr_en && ({1'b0, wr_addr} < (AW+1)'(N));
   assign nxt_idx     = idx_q + AW'(1);

   // Buffer next-state: a single in-range write per cycle, accepted in any state.
   always_comb begin
      buf_d = buf_q;
      if (wr_ok) buf_d[wr_addr] = wr_char;
   end

   // Buffer storage; resets to spaces so a blank frame is readable text.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) buf_q[i] <= 8'h20;
      end else begin
         buf_q <= buf_d;
      end
   end

   // Frame sequencer: slot timing, next-slot selection, abort and request merge.
   // Bytes are taken from buf_q, i.e. the value held on the edge the slot starts.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      row_d   = row_q;
      col_d   = col_q;
      idx_d   = idx_q;
      e_d     = lcd_e_q;
      rs_d    = lcd_rs_q;
      data_d  = lcd_data_q;
      fd_d    = 1'b0;
      pend_d  = pend_q | refresh_req;
      unique case (state_q)
         S_IDLE: ;
         S_DONE: state_d = S_IDLE;
         default: begin
            if (!init_done) begin
               // Bus ownership lost: drop the strobe, remember to redo the frame.
               state_d = S_IDLE;
               e_d     = 1'b0;
               pend_d  = 1'b1;
            end else if (!slot_end) begin
               cnt_d = cnt_q + 1'b1;
               e_d   = (cnt_q < E_LAST);
            end else begin
               cnt_d = '0;
               e_d   = 1'b1;
               if (state_q == S_CLEAR) begin
                  state_d = S_SETADDR;
                  row_d   = 2'd0;
                  rs_d    = 1'b0;
                  data_d  = row_cmd(2'd0);
               end else if (state_q == S_SETADDR) begin
                  state_d = S_CHAR;
                  col_d   = 5'd0;
                  rs_d    = 1'b1;
                  data_d  = buf_q[idx_q];
               end else if (col_q != COL_LAST) begin
                  col_d   = col_q + 1'b1;
                  idx_d   = nxt_idx;
                  data_d  = buf_q[nxt_idx];
               end else if (row_q != ROW_LAST) begin
                  state_d = S_SETADDR;
                  row_d   = row_q + 1'b1;
                  idx_d   = nxt_idx;
                  rs_d    = 1'b0;
                  data_d  = row_cmd(row_q + 1'b1);
               end else begin
                  state_d = S_DONE;
                  e_d     = 1'b0;
                  fd_d    = 1'b1;
               end
            end
         end
      endcase
      // A start (fresh or pending, also straight out of DONE) opens the first slot.
      if (start_frame) begin
         pend_d = 1'b0;
         cnt_d  = '0;
         e_d    = 1'b1;
         row_d  = 2'd0;
         col_d  = 5'd0;
         idx_d  = '0;
         rs_d   = 1'b0;
         if (USE_CLEAR != 0) begin
            state_d = S_CLEAR;
            data_d  = 8'h01;
         end else begin
            state_d = S_SETADDR;
            data_d  = row_cmd(2'd0);
         end
      end
      busy_d = (state_d != S_IDLE) || pend_d;
   end

   // Sequencer and bus registers; reset clears the strobe even mid-slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         row_q      <= 2'd0;
         col_q      <= 5'd0;
         idx_q      <= '0;
         pend_q     <= 1'b0;
         busy_q     <= 1'b1;
         fd_q       <= 1'b0;
         lcd_e_q    <= 1'b0;
         lcd_rs_q   <= 1'b0;
         lcd_data_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         row_q      <= row_d;
         col_q      <= col_d;
         idx_q      <= idx_d;
         pend_q     <= pend_d;
         busy_q     <= busy_d;
         fd_q       <= fd_d;
         lcd_e_q    <= e_d;
         lcd_rs_q   <= rs_d;
         lcd_data_q <= data_d;
      end
   end

   // Losing init_done shows as busy immediately, without waiting for a flop.
   assign busy       = busy_q | ~init_done;
   assign frame_done = fd_q;
   assign lcd_e      = lcd_e_q;
   assign lcd_rs     = lcd_rs_q;
   assign lcd_data   = lcd_data_q;
   assign lcd_rw     = 1'b0;

endmodule

// File: tb/tb_lcd_page_writer.sv
// Bench for lcd_page_writer: three instances (2x4 with clear, 2x4 without
// clear, 1x10 without clear for out-of-range addresses). Stimulus pushes the
// expected bus slots into a scoreboard queue; a monitor pops on every lcd_e
// rise and times every frame_done against the first slot of its frame.
module tb_lcd_page_writer;

   typedef struct {
      int       inst;
      bit       first;
      bit       b2b;
      bit       rs;
      bit [7:0] d;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            init_done;
   logic [2:0]      wr_en_v;
   logic [3:0]      wr_addr;
   logic [7:0]      wr_char;
   logic [2:0]      refresh_v;
   logic [2:0]      busy_v, fd_v, rs_v, rw_v, e_v;
   logic [2:0][7:0] d_v;

   exp_t sb[$];
   int   err = 0;
   int   chk = 0;
   int   cyc = 0;
   int   fd_seen = 0;
   int   fd_exp = 0;
   int   F_EXP[3] = '{82, 70, 77};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lcd_page_writer #(.ROWS(2), .COLS(4), .T_E_HIGH(2), .T_CHAR(5), .T_CMD(10), .USE_CLEAR(1)) u_a (
      .clk(clk), .rst_n(rst_n), .init_done(init_done), .wr_en(wr_en_v[0]), .wr_addr(wr_addr[2:0]),
      .wr_char(wr_char), .refresh_req(refresh_v[0]), .busy(busy_v[0]), .frame_done(fd_v[0]),
      .lcd_data(d_v[0]), .lcd_rs(rs_v[0]), .lcd_rw(rw_v[0]), .lcd_e(e_v[0]));

   lcd_page_writer #(.ROWS(2), .COLS(4), .T_E_HIGH(2), .T_CHAR(5), .T_CMD(10), .USE_CLEAR(0)) u_b (
      .clk(clk), .rst_n(rst_n), .init_done(init_done), .wr_en(wr_en_v[1]), .wr_addr(wr_addr[2:0]),
      .wr_char(wr_char), .refresh_req(refresh_v[1]), .busy(busy_v[1]), .frame_done(fd_v[1]),
      .lcd_data(d_v[1]), .lcd_rs(rs_v[1]), .lcd_rw(rw_v[1]), .lcd_e(e_v[1]));

   lcd_page_writer #(.ROWS(1), .COLS(10), .T_E_HIGH(2), .T_CHAR(5), .T_CMD(10), .USE_CLEAR(0)) u_c (
      .clk(clk), .rst_n(rst_n), .init_done(init_done), .wr_en(wr_en_v[2]), .wr_addr(wr_addr),
      .wr_char(wr_char), .refresh_req(refresh_v[2]), .busy(busy_v[2]), .frame_done(fd_v[2]),
      .lcd_data(d_v[2]), .lcd_rs(rs_v[2]), .lcd_rw(rw_v[2]), .lcd_e(e_v[2]));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
      chk++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push(input int inst, input bit first, input bit b2b, input bit rs, input bit [7:0] d);
      exp_t x;
      x.inst = inst; x.first = first; x.b2b = b2b; x.rs = rs; x.d = d;
      sb.push_back(x);
   endtask

   // Expected slots of a 2x4 frame; s holds the 8 characters, addr 0 in the top byte.
   task automatic push_frame(input int inst, input logic [63:0] s, input bit b2b);
      bit f;
      f = 1'b1;
      if (inst == 0) begin
         push(0, 1'b1, b2b, 1'b0, 8'h01);
         f = 1'b0;
      end
      push(inst, f, b2b & f, 1'b0, 8'h80);
      for (int i = 0; i < 4; i++) push(inst, 1'b0, 1'b0, 1'b1, s[63-8*i -: 8]);
      push(inst, 1'b0, 1'b0, 1'b0, 8'hC0);
      for (int i = 4; i < 8; i++) push(inst, 1'b0, 1'b0, 1'b1, s[63-8*i -: 8]);
      fd_exp++;
   endtask

   task automatic wr(input int inst, input logic [3:0] a, input logic [7:0] c);
      wr_en_v[inst] = 1'b1;
      wr_addr       = a;
      wr_char       = c;
      tick();
      wr_en_v[inst] = 1'b0;
   endtask

   task automatic wr_str(input int inst, input logic [63:0] s);
      for (int i = 0; i < 8; i++) wr(inst, 4'(i), s[63-8*i -: 8]);
   endtask

   // One-cycle request; optionally confirm the first strobe is up right after.
   task automatic refresh(input int inst, input bit chk_rise);
      refresh_v[inst] = 1'b1;
      tick();
      refresh_v[inst] = 1'b0;
      if (chk_rise) chk_eq("e_rise_after_req", 32'(e_v[inst]), 32'd1);
   endtask

   task automatic wait_fd(input int budget);
      int n;
      n = 0;
      while (fd_seen < fd_exp && n < budget) begin
         tick();
         n++;
      end
      chk++;
      if (fd_seen < fd_exp) begin
         err++;
         $display("FAIL frame_done_timeout: got %0d frames, expected %0d", fd_seen, fd_exp);
      end
   endtask

   task automatic wait_idle(input int inst);
      int n;
      n = 0;
      while (busy_v[inst] && n < 300) begin
         tick();
         n++;
      end
      chk_eq("busy_returns_low", 32'(busy_v[inst]), 32'd0);
   endtask

   // Scoreboard consumer, sampling on the falling edge.
   task automatic monitor();
      exp_t       x;
      logic [2:0] pe = '0;
      logic [7:0] sd[3];
      logic       srs[3];
      int         st[3] = '{0, 0, 0};
      int         fdc[3] = '{0, 0, 0};
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (e_v[i] && !pe[i]) begin
               chk++;
               if (sb.size() == 0) begin
                  err++;
                  $display("FAIL bus_slot inst%0d: got rs=%0d data=%02h, expected no slot", i, rs_v[i], d_v[i]);
               end else begin
                  x = sb.pop_front();
                  if (x.inst != i || x.rs !== rs_v[i] || x.d !== d_v[i]) begin
                     err++;
                     $display("FAIL bus_slot inst%0d: got rs=%0d data=%02h, expected inst%0d rs=%0d data=%02h",
                              i, rs_v[i], d_v[i], x.inst, x.rs, x.d);
                  end
                  if (x.first) begin
                     st[i] = cyc;
                     if (x.b2b) begin
                        chk++;
                        if (cyc != fdc[i] + 1) begin
                           err++;
                           $display("FAIL back_to_back_start inst%0d: got cycle %0d, expected %0d", i, cyc, fdc[i] + 1);
                        end
                     end
                  end
               end
               sd[i]  = d_v[i];
               srs[i] = rs_v[i];
            end else if (!e_v[i] && pe[i] && rst_n) begin
               chk++;
               if (d_v[i] !== sd[i] || rs_v[i] !== srs[i]) begin
                  err++;
                  $display("FAIL slot_stable inst%0d: got rs=%0d data=%02h, expected rs=%0d data=%02h",
                           i, rs_v[i], d_v[i], srs[i], sd[i]);
               end
            end
            if (fd_v[i]) begin
               fd_seen++;
               fdc[i] = cyc;
               chk++;
               if (cyc - st[i] != F_EXP[i]) begin
                  err++;
                  $display("FAIL frame_length inst%0d: got %0d cycles, expected %0d", i, cyc - st[i], F_EXP[i]);
               end
            end
            pe[i] = e_v[i];
         end
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      init_done = 1'b0;
      wr_en_v   = '0;
      refresh_v = '0;
      wr_addr   = '0;
      wr_char   = '0;
      fork
         monitor();
      join_none

      // Reset values and busy handshake with init_done.
      #3;
      chk_eq("rst_lcd_e", 32'(e_v), 32'd0);
      chk_eq("rst_lcd_rs", 32'(rs_v), 32'd0);
      chk_eq("rst_lcd_data", 32'(d_v), 32'd0);
      chk_eq("rst_frame_done", 32'(fd_v), 32'd0);
      chk_eq("rst_busy", 32'(busy_v), 32'h7);
      chk_eq("lcd_rw_zero", 32'(rw_v), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk_eq("busy_without_init", 32'(busy_v), 32'h7);
      init_done = 1'b1;
      tick();
      chk_eq("busy_after_init", 32'(busy_v), 32'd0);

      // No-clear frame: starts with the row-0 set-address, 70 cycles.
      wr_str(1, "ABCDWXYZ");
      push_frame(1, "ABCDWXYZ", 1'b0);
      refresh(1, 1'b1);
      chk_eq("noclear_first_byte", 32'(d_v[1]), 32'h80);
      wait_fd(300);
      wait_idle(1);

      // Out-of-range writes on a 10-entry buffer leave it untouched.
      wr(2, 4'd9, 8'h4B);
      wr(2, 4'd10, 8'h58);
      wr(2, 4'd15, 8'h59);
      push(2, 1'b1, 1'b0, 1'b0, 8'h80);
      for (int i = 0; i < 9; i++) push(2, 1'b0, 1'b0, 1'b1, 8'h20);
      push(2, 1'b0, 1'b0, 1'b1, 8'h4B);
      fd_exp++;
      refresh(2, 1'b1);
      wait_fd(300);
      wait_idle(2);

      // Basic frame with clear.
      wr_str(0, "ABCDWXYZ");
      push_frame(0, "ABCDWXYZ", 1'b0);
      refresh(0, 1'b1);
      chk_eq("clear_first_byte", 32'(d_v[0]), 32'h01);
      chk_eq("busy_in_frame", 32'(busy_v[0]), 32'd1);
      wait_fd(300);
      wait_idle(0);

      // Three mid-frame requests merge into exactly one back-to-back frame.
      push_frame(0, "ABCDWXYZ", 1'b0);
      push_frame(0, "ABCDWXYZ", 1'b1);
      refresh(0, 1'b1);
      repeat (10) tick();
      for (int k = 0; k < 3; k++) begin
         refresh(0, 1'b0);
         repeat (15) tick();
      end
      wait_fd(400);
      wait_idle(0);
      repeat (20) tick();
      chk_eq("no_third_frame", 32'(busy_v[0]), 32'd0);

      // Writes during row-0 chars: addr 6 lands this frame, addr 0 the next.
      push_frame(0, "ABCDWXQZ", 1'b0);
      refresh(0, 1'b1);
      repeat (25) tick();
      wr(0, 4'd6, 8'h51);
      wr(0, 4'd0, 8'h61);
      wait_fd(300);
      wait_idle(0);
      push_frame(0, "aBCDWXQZ", 1'b0);
      refresh(0, 1'b1);
      wait_fd(300);
      wait_idle(0);

      // Asynchronous reset while lcd_e is high.
      refresh(0, 1'b1);
      chk_eq("pre_reset_byte", 32'(d_v[0]), 32'h01);
      rst_n = 1'b0;
      #1;
      chk_eq("async_rst_e", 32'(e_v[0]), 32'd0);
      chk_eq("async_rst_data", 32'(d_v[0]), 32'd0);
      chk_eq("async_rst_busy", 32'(busy_v[0]), 32'd1);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      chk_eq("busy_after_reset", 32'(busy_v[0]), 32'd0);
      push_frame(0, "        ", 1'b0);
      refresh(0, 1'b1);
      wait_fd(300);
      wait_idle(0);

      // init_done drop during a char strobe aborts; full restart afterwards.
      push(0, 1'b1, 1'b0, 1'b0, 8'h01);
      push(0, 1'b0, 1'b0, 1'b0, 8'h80);
      push(0, 1'b0, 1'b0, 1'b1, 8'h20);
      push(0, 1'b0, 1'b0, 1'b1, 8'h20);
      refresh(0, 1'b1);
      repeat (26) tick();
      init_done = 1'b0;
      tick();
      chk_eq("abort_e_low", 32'(e_v[0]), 32'd0);
      chk_eq("abort_busy", 32'(busy_v[0]), 32'd1);
      chk_eq("abort_no_done", 32'(fd_v[0]), 32'd0);
      repeat (5) tick();
      chk_eq("abort_stays_idle", 32'(e_v[0]), 32'd0);
      push_frame(0, "        ", 1'b0);
      init_done = 1'b1;
      wait_fd(300);
      wait_idle(0);

      repeat (5) tick();
      chk_eq("scoreboard_drained", 32'(sb.size()), 32'd0);
      chk_eq("frame_done_count", 32'(fd_seen), 32'(fd_exp));
      $display("Result: errors=%0d of %0d checks", err, chk);
      $finish;
   end

endmodule
